payment_collector: RTL and testbench
====================================

PAYMENT_COLLECTOR -- requirements
Module: payment_collector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning idle cycles without an accepted coin before an automatic refund (range 2..1023).
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port price_valid  in  1  one-cycle strobe, price is valid.
REQ-005 SHALL have port price  in  16  amount due, in colones.
REQ-006 SHALL have port coin_valid  in  1  one-cycle strobe, coin inserted.
REQ-007 SHALL have port coin_code  in  3  coin code: 1=5, 2=10, 3=25, 4=50, 5=100, 6=500 colones; 0 and 7 invalid.
REQ-008 SHALL have port cancel  in  1  user abort request.
REQ-009 SHALL have port pago_recibido  out  1  one-cycle pulse, payment complete (feeds the coffee FSM).
REQ-010 SHALL have port change_valid  out  1  one-cycle pulse qualifying change.
REQ-011 SHALL have port change  out  16  change to return.
REQ-012 SHALL have port refund_valid  out  1  one-cycle pulse qualifying refund.
REQ-013 SHALL have port refund  out  16  credit returned on abort or timeout.
REQ-014 SHALL have port credit  out  16  accumulated credit, registered.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port coin_reject  out  1  one-cycle pulse, coin not accepted.

Function
REQ-017 SHALL implement states IDLE, COLLECT, PAID and REFUND; all outputs SHALL be registered.
REQ-018 IDLE: price_valid with price!=0 SHALL latch price and enter COLLECT on the next cycle, with timeout counter=0 and credit=0; price==0 SHALL be ignored.
REQ-019 price_valid outside IDLE SHALL be ignored, and the latched price SHALL NOT change.
REQ-020 COLLECT: a valid coin SHALL add its value to credit, visible one cycle later, and SHALL clear the timeout counter.
REQ-021 Credit addition SHALL be 17-bit internally and saturate at 16'hFFFF.
REQ-022 If credit+coin >= price, the next cycle SHALL enter PAID, pulse pago_recibido for 1 cycle, and pulse change_valid with change=credit+coin-price.
REQ-023 PAID SHALL last exactly 1 cycle, then enter IDLE with credit=0.
REQ-024 cancel in COLLECT SHALL enter REFUND; refund=credit and refund_valid SHALL pulse 1 cycle, then IDLE with credit=0.
REQ-025 When cancel and coin_valid occur in the same cycle, cancel SHALL win and coin_reject SHALL pulse.
REQ-026 The timeout counter SHALL increment every COLLECT cycle without an accepted coin; at TIMEOUT_CYCLES-1 it SHALL enter REFUND, and a coin in that same cycle SHALL be accepted instead (no timeout).
REQ-027 A coin with an invalid code, or any coin_valid in IDLE, PAID or REFUND, SHALL pulse coin_reject the next cycle, with no credit change.
REQ-028 REFUND with credit=0 SHALL still pulse refund_valid with refund=0.
REQ-029 change and refund SHALL hold their last value between pulses.

Reset
REQ-030 reset SHALL force IDLE with credit=0, change=0, refund=0, timeout counter=0, latched price=0, and all pulses low, on the next edge.
REQ-031 reset mid-COLLECT SHALL discard credit without asserting refund_valid.

Configuration
REQ-032 With macro PAYMENT_CHANGE_RETURN_EN defined, change SHALL be computed per REQ-022.
REQ-033 Without PAYMENT_CHANGE_RETURN_EN, change SHALL stay 0 and change_valid SHALL stay low (overpayment kept); pago_recibido timing SHALL be unchanged.

Structure
REQ-034 A shared package payment_pkg SHALL hold the state enum, the coin code constants, the coin value constants (16-bit), and the default timeout.
REQ-035 A combinational sub-module coin_decoder SHALL map coin_code to a 16-bit value plus a valid flag.

Verification
REQ-036 Price 500, then coins 100,100,100,100,100 -> pago_recibido on the cycle after the 5th coin, change=0, credit back to 0 after PAID.
REQ-037 Price 750, then coin 500, coin 500 -> pago_recibido=1, change=250 (macro defined); change_valid=0 and change=0 (macro undefined).
REQ-038 Price 1000, coin 50, then cancel asserted together with coin 100 -> refund_valid=1, refund=50, coin_reject=1.
REQ-039 TIMEOUT_CYCLES=8, price 1500, coin 25, then no activity -> refund_valid 8 cycles after the coin was accepted, refund=25, busy=0 afterwards.
REQ-040 Coin code 7 in COLLECT, and coin 100 in IDLE -> coin_reject pulses, credit unchanged.
REQ-041 Price 2000, coins 500,500, reset mid-COLLECT -> credit=0, state IDLE, refund_valid never asserted.

Source files
------------

// File: rtl/payment_pkg.sv
// Shared types and constants for the coin payment collector.
// Coin codes, their colon values, FSM state encoding and the default idle timeout.
package payment_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PAID    = 2'd2,
      ST_REFUND  = 2'd3
   } state_e;

   localparam logic [2:0] COIN_5   = 3'd1;
   localparam logic [2:0] COIN_10  = 3'd2;
   localparam logic [2:0] COIN_25  = 3'd3;
   localparam logic [2:0] COIN_50  = 3'd4;
   localparam logic [2:0] COIN_100 = 3'd5;
   localparam logic [2:0] COIN_500 = 3'd6;

   localparam logic [15:0] VALUE_5   = 16'd5;
   localparam logic [15:0] VALUE_10  = 16'd10;
   localparam logic [15:0] VALUE_25  = 16'd25;
   localparam logic [15:0] VALUE_50  = 16'd50;
   localparam logic [15:0] VALUE_100 = 16'd100;
   localparam logic [15:0] VALUE_500 = 16'd500;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;
   localparam int TIMER_W                = 10;

   // Credit never wraps: a carry out of 16 bits pins the result at full scale.
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin code to colon value decoder.
// Codes 0 and 7 are not coins and decode to value 0 with valid low.
module coin_decoder
   import payment_pkg::*;
(
   input  logic [2:0]  code,
   output logic [15:0] value,
   output logic        valid
);

   always_comb begin
      value = 16'd0;
      valid = 1'b1;
      case (code)
         COIN_5:   value = VALUE_5;
         COIN_10:  value = VALUE_10;
         COIN_25:  value = VALUE_25;
         COIN_50:  value = VALUE_50;
         COIN_100: value = VALUE_100;
         COIN_500: value = VALUE_500;
         default:  valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/payment_collector.sv
// Coin payment collector: latches a price, accumulates coins, reports payment, change and refunds.
// Define PAYMENT_CHANGE_RETURN_EN to return overpayment as change; otherwise overpayment is kept.
//
// state   | meaning
// IDLE    | waiting for a nonzero price
// COLLECT | accepting coins, idle timeout running
// PAID    | one-cycle completion, credit cleared on exit
// REFUND  | one-cycle abort/timeout, credit cleared on exit
module payment_collector
   import payment_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        price_valid,
   input  logic [15:0] price,
   input  logic        coin_valid,
   input  logic [2:0]  coin_code,
   input  logic        cancel,
   output logic        pago_recibido,
   output logic        change_valid,
   output logic [15:0] change,
   output logic        refund_valid,
   output logic [15:0] refund,
   output logic [15:0] credit,
   output logic        busy,
   output logic        coin_reject
);

   localparam logic [1:0] IDLE    = ST_IDLE;
   localparam logic [1:0] COLLECT = ST_COLLECT;
   localparam logic [1:0] PAID    = ST_PAID;
   localparam logic [1:0] REFUND  = ST_REFUND;

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [15:0]        price_q;
   logic [TIMER_W-1:0] timer;

   logic [15:0]        coin_value;
   logic               coin_ok;
   logic [15:0]        credit_sum;
   logic               coin_accept;
   logic               paid_now;
   logic               timer_done;
   logic               start_collect;
   logic               enter_refund;

   coin_decoder u_coin_decoder (
      .code  (coin_code),
      .value (coin_value),
      .valid (coin_ok)
   );

   assign credit_sum    = sat_add(credit, coin_value);
   assign paid_now      = (credit_sum >= price_q);
   assign timer_done    = (timer == TIMER_LAST);
   // Cancel beats a coin in the same cycle; that coin is bounced.
   assign coin_accept   = (state == COLLECT) && coin_valid && coin_ok && !cancel;
   assign start_collect = (state == IDLE) && price_valid && (price != 16'd0);
   assign enter_refund  = (state == COLLECT) && (state_next == REFUND);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_collect) state_next = COLLECT;
         end
         COLLECT: begin
            if (cancel)
               state_next = REFUND;
            else if (coin_accept)
               state_next = paid_now ? PAID : COLLECT;
            else if (timer_done)
               state_next = REFUND;
         end
         PAID:    state_next = IDLE;
         REFUND:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         price_q       <= 16'd0;
         credit        <= 16'd0;
         timer         <= '0;
         change        <= 16'd0;
         change_valid  <= 1'b0;
         refund        <= 16'd0;
         refund_valid  <= 1'b0;
         pago_recibido <= 1'b0;
         coin_reject   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_next;
         busy          <= (state_next != IDLE);
         coin_reject   <= coin_valid && !coin_accept;
         pago_recibido <= coin_accept && paid_now;
         refund_valid  <= enter_refund;
         if (enter_refund) refund <= credit;

`ifdef PAYMENT_CHANGE_RETURN_EN
         change_valid <= coin_accept && paid_now;
         if (coin_accept && paid_now) change <= credit_sum - price_q;
`else
         change_valid <= 1'b0;
         change       <= 16'd0;
`endif

         if (start_collect) begin
            price_q <= price;
            credit  <= 16'd0;
            timer   <= '0;
         end else if (coin_accept) begin
            credit <= credit_sum;
            timer  <= '0;
         end else if (state == COLLECT) begin
            timer <= timer + 1'b1;
         end else if ((state == PAID) || (state == REFUND)) begin
            credit <= 16'd0;
         end
      end
   end

endmodule

// File: tb/tb_payment_collector.sv
// Scoreboard bench for payment_collector: directed scenarios followed by random traffic.
// A session-level reference model predicts every cycle's outputs; a monitor compares them.
module tb_payment_collector;

   localparam int T = 8;

   logic        clock;
   logic        reset;
   logic        price_valid;
   logic [15:0] price;
   logic        coin_valid;
   logic [2:0]  coin_code;
   logic        cancel;
   logic        pago_recibido;
   logic        change_valid;
   logic [15:0] change;
   logic        refund_valid;
   logic [15:0] refund;
   logic [15:0] credit;
   logic        busy;
   logic        coin_reject;

   payment_collector #(.TIMEOUT_CYCLES(T)) dut (
      .clock         (clock),
      .reset         (reset),
      .price_valid   (price_valid),
      .price         (price),
      .coin_valid    (coin_valid),
      .coin_code     (coin_code),
      .cancel        (cancel),
      .pago_recibido (pago_recibido),
      .change_valid  (change_valid),
      .change        (change),
      .refund_valid  (refund_valid),
      .refund        (refund),
      .credit        (credit),
      .busy          (busy),
      .coin_reject   (coin_reject)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct packed {
      logic        pago;
      logic        cv;
      logic [15:0] chg;
      logic        rv;
      logic [15:0] rf;
      logic [15:0] cr;
      logic        bsy;
      logic        rej;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;

   // Session-level model: an open session collects, a closing session lasts one cycle.
   int coin_val[8] = '{0, 5, 10, 25, 50, 100, 500, 0};
   int m_open = 0, m_closing = 0, m_idle = 0;
   int m_price = 0, m_credit = 0, m_change = 0, m_refund = 0;

   task automatic step(input logic rst, input logic pv, input logic [15:0] p,
                       input logic cv, input logic [2:0] cc, input logic can);
      exp_t e;
      int   val;
      @(negedge clock);
      reset       = rst;
      price_valid = pv;
      price       = p;
      coin_valid  = cv;
      coin_code   = cc;
      cancel      = can;
      val = coin_val[cc];
      e = '0;
      if (rst) begin
         m_open = 0; m_closing = 0; m_idle = 0;
         m_credit = 0; m_change = 0; m_refund = 0;
      end else if (m_closing != 0) begin
         e.rej = cv;
         m_closing = 0;
         m_credit = 0;
      end else if (m_open == 0) begin
         e.rej = cv;
         if (pv && p != 16'd0) begin
            m_open = 1; m_price = int'(p); m_credit = 0; m_idle = 0;
         end
      end else if (can) begin
         e.rej = cv;
         e.rv = 1'b1;
         m_refund = m_credit;
         m_open = 0; m_closing = 1;
      end else if (cv && val > 0) begin
         m_credit = (m_credit + val > 65535) ? 65535 : m_credit + val;
         m_idle = 0;
         if (m_credit >= m_price) begin
            e.pago = 1'b1;
`ifdef PAYMENT_CHANGE_RETURN_EN
            e.cv = 1'b1;
            m_change = m_credit - m_price;
`endif
            m_open = 0; m_closing = 1;
         end
      end else begin
         e.rej = cv;
         if (m_idle == T - 1) begin
            e.rv = 1'b1;
            m_refund = m_credit;
            m_open = 0; m_closing = 1;
         end else begin
            m_idle++;
         end
      end
      e.chg = 16'(m_change);
      e.rf  = 16'(m_refund);
      e.cr  = 16'(m_credit);
      e.bsy = (m_open != 0) || (m_closing != 0);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic set_price(input logic [15:0] p);
      step(1'b0, 1'b1, p, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic coin(input logic [2:0] cc);
      step(1'b0, 1'b0, 16'd0, 1'b1, cc, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
      if (act !== want) begin
         n_miss++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, want);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk("pago_recibido", 16'(pago_recibido), 16'(e.pago));
            chk("change_valid",  16'(change_valid),  16'(e.cv));
            chk("change",        change,             e.chg);
            chk("refund_valid",  16'(refund_valid),  16'(e.rv));
            chk("refund",        refund,             e.rf);
            chk("credit",        credit,             e.cr);
            chk("busy",          16'(busy),          16'(e.bsy));
            chk("coin_reject",   16'(coin_reject),   16'(e.rej));
         end
      end
   end

   initial begin
      int rate;
      reset = 1'b1; price_valid = 1'b0; price = 16'd0;
      coin_valid = 1'b0; coin_code = 3'd0; cancel = 1'b0;

      repeat (3) step(1'b1, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0);
      idle(2);

      // 500 paid with five 100s, exact payment
      set_price(16'd500);
      repeat (5) coin(3'd5);
      idle(2);

      // 750 paid with two 500s, overpayment of 250
      set_price(16'd750);
      coin(3'd6);
      coin(3'd6);
      idle(2);

      // cancel with a simultaneous coin
      set_price(16'd1000);
      coin(3'd4);
      step(1'b0, 1'b0, 16'd0, 1'b1, 3'd5, 1'b1);
      idle(2);

      // idle timeout after one coin
      set_price(16'd1500);
      coin(3'd3);
      idle(T + 3);

      // invalid code in COLLECT, coin while IDLE, cancel with zero credit
      coin(3'd5);
      set_price(16'd200);
      coin(3'd7);
      coin(3'd0);
      step(1'b0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b1);
      idle(2);

      // reset mid-collect discards credit
      set_price(16'd2000);
      coin(3'd6);
      coin(3'd6);
      step(1'b1, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0);
      idle(3);

      // zero price ignored; new price ignored while collecting; coin during PAID
      set_price(16'd0);
      idle(1);
      set_price(16'd300);
      set_price(16'd10);
      coin(3'd5);
      coin(3'd5);
      coin(3'd5);
      coin(3'd6);
      idle(2);

      // smallest price with change
      set_price(16'd1);
      coin(3'd1);
      idle(2);

      // saturation at full scale
      set_price(16'hFFFF);
      repeat (132) coin(3'd6);
      idle(2);

      // random traffic in blocks with varying coin density
      for (int blk = 0; blk < 60; blk++) begin
         rate = $urandom_range(1, 12);
         for (int i = 0; i < 50; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(1, 1500)),
                 ($urandom_range(0, rate) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 49) == 0));
         end
      end
      idle(2);

      @(negedge clock);
      repeat (3) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
